// File: rtl/product_byte_streamer.sv
// Buffers 16-bit product words in a small FIFO and streams each one to a
// byte-wide pin reader as low byte then high byte, with a valid/ack handshake.
module product_byte_streamer #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [W-1:0]             in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic                     out_hi,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     rd_next;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        byte_q, byte_d;
  logic              push;
  logic              pop;

  assign in_ready = rst_n && ena && (count_q < FULL);
  assign push     = in_valid && in_ready;
  assign pop      = ena && (state_q == HI) && out_ack;
  assign rd_next  = rd_ptr_q + PW'(1);

  // Storage is not reset; the IDLE state only reads the head when count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (ena) begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_d = LO;
            byte_d  = mem_q[rd_ptr_q][7:0];
          end
        end
        LO: begin
          if (out_ack) begin
            state_d = HI;
            byte_d  = mem_q[rd_ptr_q][15:8];
          end
        end
        HI: begin
          // A word pushed on this same edge is not bypassed: it is picked up from IDLE.
          if (out_ack) begin
            rd_ptr_d = rd_next;
            if (count_q >= CW'(2)) begin
              state_d = LO;
              byte_d  = mem_q[rd_next][7:0];
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      byte_q   <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_byte  = byte_q;
  assign out_valid = (state_q != IDLE);
  assign out_hi    = (state_q == HI);
  assign count     = count_q;

endmodule

// File: tb/tb_product_byte_streamer.sv
// Self-checking bench for product_byte_streamer: a scoreboard of expected
// bytes is filled on accepted pushes and drained as the reader acknowledges.
module tb_product_byte_streamer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ack;
  logic        out_hi;
  logic [2:0]  count;

  typedef struct packed {
    logic [7:0] b;
    logic       hi;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int       expCount;
  int       tests;
  int       failures;
  logic     acc;

  product_byte_streamer #(.DEPTH(DEPTH), .W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_byte (out_byte),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .out_hi   (out_hi),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, update the reference model, then sample #1 after the edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic a,
                               input logic e, input logic r, output logic accepted);
    sbEntry_t exp;
    logic canPush;
    in_valid = v;
    in_data  = d;
    out_ack  = a;
    ena      = e;
    rst_n    = r;
    accepted = 1'b0;
    #1;
    if (!r) begin
      checkOutput("in_ready_rst", 16'(in_ready), 16'd0);
      sbQ.delete();
      expCount = 0;
    end else if (!e) begin
      checkOutput("in_ready_ena0", 16'(in_ready), 16'd0);
    end else begin
      canPush = (expCount < DEPTH);
      checkOutput("in_ready", 16'(in_ready), 16'(canPush));
      if (out_valid === 1'b1 && a) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_byte", 16'(out_byte), 16'hFFFF);
        end else begin
          exp = sbQ.pop_front();
          checkOutput("out_byte", 16'(out_byte), 16'(exp.b));
          checkOutput("out_hi", 16'(out_hi), 16'(exp.hi));
          if (exp.hi) expCount--;
        end
      end
      if (v && canPush) begin
        sbQ.push_back('{b: d[7:0], hi: 1'b0});
        sbQ.push_back('{b: d[15:8], hi: 1'b1});
        expCount++;
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("count", 16'(count), 16'(expCount));
  endtask

  task automatic drain();
    int guard;
    logic dummy;
    guard = 0;
    while (sbQ.size() > 0 && guard < 64) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, dummy);
      guard++;
    end
    checkOutput("drain_left", 16'(sbQ.size()), 16'd0);
    checkOutput("drain_idle", 16'(out_valid), 16'd0);
  endtask

  initial begin
    int idx;
    int guard;
    bit started;
    tests    = 0;
    failures = 0;
    expCount = 0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ack  = 1'b0;
    ena      = 1'b0;
    rst_n    = 1'b0;

    // Reset with in_valid and out_ack asserted must be ignored.
    applyStimulus(1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, acc);
    checkOutput("rst_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_byte", 16'(out_byte), 16'h00);
    checkOutput("rst_hi", 16'(out_hi), 16'd0);
    checkOutput("rst_in_ready", 16'(in_ready), 16'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, acc);

    // Single word.
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, acc);
    checkOutput("single_wait", 16'(out_valid), 16'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, acc);
    checkOutput("single_valid", 16'(out_valid), 16'd1);
    checkOutput("single_lo", 16'(out_byte), 16'h00EF);
    checkOutput("single_hi0", 16'(out_hi), 16'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, acc);
    checkOutput("single_hb", 16'(out_byte), 16'h00BE);
    checkOutput("single_hi1", 16'(out_hi), 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, acc);
    checkOutput("single_done", 16'(out_valid), 16'd0);

    // Fill to DEPTH without acks, then a fifth word must be refused.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 16'(i) * 16'h0101, 1'b0, 1'b1, 1'b1, acc);
    end
    checkOutput("full_count", 16'(count), 16'd4);
    checkOutput("full_ready", 16'(in_ready), 16'd0);
    applyStimulus(1'b1, 16'h0505, 1'b0, 1'b1, 1'b1, acc);
    checkOutput("full_byte", 16'(out_byte), 16'h0001);
    drain();

    // Streaming with out_ack held high; no gap once the first byte appears.
    idx = 1;
    guard = 0;
    started = 1'b0;
    while ((idx <= 6 || sbQ.size() > 0) && guard < 200) begin
      if (started && sbQ.size() > 0) checkOutput("stream_gap", 16'(out_valid), 16'd1);
      if (out_valid === 1'b1) started = 1'b1;
      applyStimulus(idx <= 6, 16'(idx) * 16'h1100, 1'b1, 1'b1, 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    checkOutput("stream_timeout", 16'(guard < 200), 16'd1);
    checkOutput("stream_idle", 16'(out_valid), 16'd0);

    // Push during a HI ack with two words held.
    applyStimulus(1'b1, 16'hA1A2, 1'b0, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 16'hB1B2, 1'b0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, acc);
    checkOutput("simul2_hi", 16'(out_hi), 16'd1);
    applyStimulus(1'b1, 16'hC1C2, 1'b1, 1'b1, 1'b1, acc);
    checkOutput("simul2_count", 16'(count), 16'd2);
    checkOutput("simul2_next", 16'(out_byte), 16'h00B2);
    drain();

    // Push during a HI ack with one word held: one IDLE cycle, then the new word.
    applyStimulus(1'b1, 16'hD1D2, 1'b0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 16'hE1E2, 1'b1, 1'b1, 1'b1, acc);
    checkOutput("simul1_gap", 16'(out_valid), 16'd0);
    checkOutput("simul1_count", 16'(count), 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, acc);
    checkOutput("simul1_valid", 16'(out_valid), 16'd1);
    checkOutput("simul1_lo", 16'(out_byte), 16'h00E2);
    drain();

    // Enable low in HI holds everything; reset in HI discards the word.
    applyStimulus(1'b1, 16'hA55A, 1'b0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, 1'b1, acc);
    checkOutput("ena0_byte", 16'(out_byte), 16'h00A5);
    checkOutput("ena0_hi", 16'(out_hi), 16'd1);
    checkOutput("ena0_valid", 16'(out_valid), 16'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, acc);
    checkOutput("rstHI_valid", 16'(out_valid), 16'd0);
    checkOutput("rstHI_byte", 16'(out_byte), 16'h00);
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, acc);
    checkOutput("post_rst_valid", 16'(out_valid), 16'd1);
    checkOutput("post_rst_lo", 16'(out_byte), 16'h0034);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
